// File: rtl/square_wave_period_meter.sv
// square_wave_period_meter
//   Squares a signed 16-bit audio-rate signal with a hysteresis comparator,
//   measures its high time and period in audio samples, and converts the
//   period to a frequency in Hz (unsigned Q20.4) with a restoring divider.
//
// Ports:
//   clk               system clock
//   reset             asynchronous, active-high reset
//   audio_clk_en      one-clk strobe per audio sample; gates sampling/counting
//   in                signed audio input sample
//   period_samples    last measured period, in samples
//   high_samples      high time of that period, in samples
//   measurement_valid one-clk pulse when period/high outputs update
//   freq_q4           SAMPLE_RATE/period in Hz, unsigned Q20.4
//   freq_valid        one-clk pulse when freq_q4 updates
//   no_signal         high while no valid measurement is current
module square_wave_period_meter #(
    parameter int SAMPLE_RATE     = 48000,
    parameter int THRESH_HI       = 12288,
    parameter int THRESH_LO       = 4096,
    parameter int TIMEOUT_SAMPLES = 48000,
    parameter int COUNT_WIDTH     = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   audio_clk_en,
    input  logic signed [15:0]     in,
    output logic [COUNT_WIDTH-1:0] period_samples,
    output logic [COUNT_WIDTH-1:0] high_samples,
    output logic                   measurement_valid,
    output logic [23:0]            freq_q4,
    output logic                   freq_valid,
    output logic                   no_signal
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic signed [15:0]   TH_HI_C    = 16'(THRESH_HI);
    localparam logic signed [15:0]   TH_LO_C    = 16'(THRESH_LO);
    localparam logic [COUNT_WIDTH:0] TIMEOUT_C  = (COUNT_WIDTH + 1)'(TIMEOUT_SAMPLES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE_C = COUNT_WIDTH'(32'd1);
    // Q4 result: the dividend carries four fractional bits.
    localparam logic [31:0]          DIVIDEND_C = 32'(SAMPLE_RATE * 16);

    // Clamp a 32-bit quotient into the 24-bit frequency output.
    function automatic logic [23:0] sat24(input logic [31:0] q);
        logic [23:0] r;
        if (q[31:24] != 8'd0) begin
            r = 24'hFF_FFFF;
        end else begin
            r = q[23:0];
        end
        return r;
    endfunction

    logic                   level_r;
    logic [1:0]             state_r;
    logic [COUNT_WIDTH-1:0] high_cnt_r;
    logic [COUNT_WIDTH-1:0] low_cnt_r;

    logic                   level_next_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [COUNT_WIDTH:0]   sum_s;
    logic                   timeout_s;
    logic                   publish_s;

    logic                   busy_r;
    logic                   done_r;
    logic [4:0]             iter_r;
    logic [COUNT_WIDTH-1:0] rem_r;
    logic [31:0]            quo_r;
    logic [COUNT_WIDTH-1:0] divisor_r;

    logic [COUNT_WIDTH:0]   rem_shift_s;
    logic                   ge_s;
    logic [COUNT_WIDTH-1:0] rem_next_s;

    // Hysteresis comparator: next squared level from the current sample.
    always_comb begin
        level_next_s = level_r;
        if (in >= TH_HI_C) begin
            level_next_s = 1'b1;
        end else if (in <= TH_LO_C) begin
            level_next_s = 1'b0;
        end else begin
            level_next_s = level_r;
        end
    end

    assign rise_s = level_next_s & ~level_r;
    assign fall_s = ~level_next_s & level_r;

    // low_cnt is zero in HIGH, so "sum + 1" is the post-edge total for every
    // non-rise edge in HIGH or LOW, including the falling edge.
    assign sum_s     = {1'b0, high_cnt_r} + {1'b0, low_cnt_r};
    assign timeout_s = (sum_s + {{COUNT_WIDTH{1'b0}}, 1'b1}) > TIMEOUT_C;
    assign publish_s = audio_clk_en & (state_r == ST_LOW) & rise_s;

    // Comparator level, measurement state machine and published period/high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r           <= 1'b0;
            state_r           <= ST_SYNC;
            high_cnt_r        <= '0;
            low_cnt_r         <= '0;
            period_samples    <= '0;
            high_samples      <= '0;
            measurement_valid <= 1'b0;
            no_signal         <= 1'b1;
        end else begin
            measurement_valid <= 1'b0;
            if (audio_clk_en) begin
                level_r <= level_next_s;
                case (state_r)
                    ST_SYNC: begin
                        if (rise_s) begin
                            high_cnt_r <= CNT_ONE_C;
                            low_cnt_r  <= '0;
                            state_r    <= ST_HIGH;
                        end else begin
                            state_r    <= ST_SYNC;
                        end
                    end
                    ST_HIGH: begin
                        if (timeout_s) begin
                            high_cnt_r <= '0;
                            low_cnt_r  <= '0;
                            no_signal  <= 1'b1;
                            state_r    <= ST_SYNC;
                        end else if (fall_s) begin
                            low_cnt_r  <= CNT_ONE_C;
                            state_r    <= ST_LOW;
                        end else begin
                            high_cnt_r <= high_cnt_r + CNT_ONE_C;
                        end
                    end
                    ST_LOW: begin
                        // A rise beats a simultaneous timeout.
                        if (rise_s) begin
                            period_samples    <= sum_s[COUNT_WIDTH-1:0];
                            high_samples      <= high_cnt_r;
                            measurement_valid <= 1'b1;
                            no_signal         <= 1'b0;
                            high_cnt_r        <= CNT_ONE_C;
                            low_cnt_r         <= '0;
                            state_r           <= ST_HIGH;
                        end else if (timeout_s) begin
                            high_cnt_r <= '0;
                            low_cnt_r  <= '0;
                            no_signal  <= 1'b1;
                            state_r    <= ST_SYNC;
                        end else begin
                            low_cnt_r  <= low_cnt_r + CNT_ONE_C;
                        end
                    end
                    default: begin
                        high_cnt_r <= '0;
                        low_cnt_r  <= '0;
                        state_r    <= ST_SYNC;
                    end
                endcase
            end else begin
                level_r <= level_r;
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[31]};
        ge_s        = rem_shift_s >= {1'b0, divisor_r};
        if (ge_s) begin
            rem_next_s = COUNT_WIDTH'(rem_shift_s - {1'b0, divisor_r});
        end else begin
            rem_next_s = rem_shift_s[COUNT_WIDTH-1:0];
        end
    end

    // Sequential divider: loads on publish, 32 iterations, result one clk later.
    // A new publish reloads the operands, discarding any divide in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            iter_r     <= 5'd0;
            rem_r      <= '0;
            quo_r      <= 32'd0;
            divisor_r  <= '0;
            freq_q4    <= 24'd0;
            freq_valid <= 1'b0;
        end else begin
            if (done_r) begin
                freq_q4    <= sat24(quo_r);
                freq_valid <= 1'b1;
            end else begin
                freq_valid <= 1'b0;
            end
            if (publish_s) begin
                busy_r    <= 1'b1;
                done_r    <= 1'b0;
                iter_r    <= 5'd0;
                rem_r     <= '0;
                quo_r     <= DIVIDEND_C;
                divisor_r <= sum_s[COUNT_WIDTH-1:0];
            end else if (busy_r) begin
                rem_r  <= rem_next_s;
                quo_r  <= {quo_r[30:0], ge_s};
                iter_r <= iter_r + 5'd1;
                busy_r <= (iter_r != 5'd31);
                done_r <= (iter_r == 5'd31);
            end else begin
                done_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_wave_period_meter.sv
module tb_square_wave_period_meter;

    localparam int TO = 2000;
    localparam int CW = 17;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic signed [15:0]   smp;
    logic [CW-1:0]        period_samples;
    logic [CW-1:0]        high_samples;
    logic                 measurement_valid;
    logic [23:0]          freq_q4;
    logic                 freq_valid;
    logic                 no_signal;

    square_wave_period_meter #(
        .TIMEOUT_SAMPLES(TO),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .audio_clk_en(en),
        .in(smp),
        .period_samples(period_samples),
        .high_samples(high_samples),
        .measurement_valid(measurement_valid),
        .freq_q4(freq_q4),
        .freq_valid(freq_valid),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int cyc; int period; int high; } meas_t;
    typedef struct { int cyc; int freq; } freq_t;
    meas_t meas_q[$];
    freq_t freq_q[$];

    // reference model state (sample-index based)
    logic m_lvl;
    logic m_track;
    logic m_nosig;
    int   sidx;
    int   rise_idx;
    int   fall_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_lvl    = 1'b0;
        m_track  = 1'b0;
        m_nosig  = 1'b1;
        sidx     = 0;
        rise_idx = 0;
        fall_idx = 0;
        meas_q.delete();
        freq_q.delete();
    endtask

    task automatic model_sample(input logic signed [15:0] v);
        logic nl;
        logic rise;
        logic fall;
        int   p;
        nl = m_lvl;
        if (v >= 12288) nl = 1'b1;
        else if (v <= 4096) nl = 1'b0;
        rise  = nl & ~m_lvl;
        fall  = ~nl & m_lvl;
        m_lvl = nl;
        sidx++;
        if (!m_track) begin
            if (rise) begin
                m_track  = 1'b1;
                rise_idx = sidx;
            end
        end else if (rise) begin
            p = sidx - rise_idx;
            meas_q.push_back('{cyc, p, fall_idx - rise_idx});
            while (freq_q.size() > 0 && freq_q[$].cyc > cyc) void'(freq_q.pop_back());
            freq_q.push_back('{cyc + 33, 768000 / p});
            rise_idx = sidx;
            m_nosig  = 1'b0;
        end else if (sidx - rise_idx + 1 > TO) begin
            m_track = 1'b0;
            m_nosig = 1'b1;
        end else if (fall) begin
            fall_idx = sidx;
        end
    endtask

    task automatic tick(input logic e, input logic signed [15:0] v);
        @(negedge clk);
        en  = e;
        smp = v;
        @(posedge clk);
        cyc++;
        if (e && !reset) model_sample(v);
    endtask

    task automatic put(input logic signed [15:0] v, input int gap);
        tick(1'b1, v);
        for (int i = 1; i < gap; i++) tick(1'b0, v);
    endtask

    task automatic case1(input int reps, input int gap);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 10; i++) put(16'sd16384, gap);
            for (int i = 0; i < 14; i++) put(16'sd0, gap);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, smp);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        m_reset();
        idle(2);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_period"}, period_samples, 0);
        chk({tag, "_high"}, high_samples, 0);
        chk({tag, "_freq"}, freq_q4, 0);
        chk({tag, "_mvalid"}, measurement_valid, 0);
        chk({tag, "_fvalid"}, freq_valid, 0);
        chk({tag, "_nosig"}, no_signal, 1);
    endtask

    // async reset landing between clock edges
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        chk_cleared(tag);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // scoreboard: every clk, pulses must match exactly what the model expects
    always @(negedge clk) begin : mon
        meas_t mm;
        freq_t ff;
        if (!reset) begin
            if (meas_q.size() > 0 && meas_q[0].cyc == cyc) begin
                mm = meas_q.pop_front();
                chk("meas_pulse", measurement_valid, 1);
                chk("period", period_samples, mm.period);
                chk("high", high_samples, mm.high);
            end else begin
                chk("meas_pulse", measurement_valid, 0);
            end
            if (freq_q.size() > 0 && freq_q[0].cyc == cyc) begin
                ff = freq_q.pop_front();
                chk("freq_pulse", freq_valid, 1);
                chk("freq", freq_q4, ff.freq);
            end else begin
                chk("freq_pulse", freq_valid, 0);
            end
            chk("no_signal", no_signal, m_nosig);
        end
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        smp   = 16'sd0;
        m_reset();
        idle(3);
        chk_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: 10 high / 14 low
        case1(3, 10);
        idle(40);
        chk("t1_period", period_samples, 24);
        chk("t1_high", high_samples, 10);
        chk("t1_freq", freq_q4, 32000);
        chk("t1_nosig", no_signal, 0);

        // 2: alternate every sample
        for (int i = 0; i < 12; i++) put((i % 2 == 0) ? 16'sd16384 : 16'sd0, 20);
        idle(40);
        chk("t2_period", period_samples, 2);
        chk("t2_high", high_samples, 1);
        chk("t2_freq", freq_q4, 384000);

        // 3: inside hysteresis band only
        sync_reset();
        for (int i = 0; i < 60; i++) put((i % 2 == 0) ? 16'sd8000 : 16'sd9000, 2);
        idle(40);
        chk("t3_period", period_samples, 0);
        chk("t3_high", high_samples, 0);
        chk("t3_freq", freq_q4, 0);
        chk("t3_nosig", no_signal, 1);

        // 4: lock, then hold high until timeout, then re-lock
        case1(2, 2);
        for (int i = 0; i < TO + 10; i++) put(16'sd16384, 1);
        idle(5);
        chk("t4_nosig", no_signal, 1);
        chk("t4_period", period_samples, 24);
        chk("t4_freq", freq_q4, 32000);
        case1(3, 2);
        idle(40);
        chk("t4_relock_nosig", no_signal, 0);

        // 5: reset during LOW, then during a divide
        for (int i = 0; i < 10; i++) put(16'sd16384, 2);
        for (int i = 0; i < 5; i++) put(16'sd0, 2);
        async_reset("t5_low");
        case1(1, 2);
        for (int i = 0; i < 5; i++) put(16'sd16384, 2);
        async_reset("t5_div");
        idle(50);

        // 6: fast enable aborts every divide, slower enable resumes results
        case1(4, 1);
        case1(3, 64);
        idle(50);

        chk("meas_q_drained", meas_q.size(), 0);
        chk("freq_q_drained", freq_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
